pc_seq: RTL and testbench
=========================

// Module: pc_seq
// PURPOSE
//  Sequencer that owns the control inputs of the 16-bit program counter (LO/HI/CI/WR/INC).
//  Accepts one command at a time from the instruction decoder: fetch-advance, relative branch,
//  absolute jump or vector load. Turns each command into the exact cycle sequence of WR/INC
//  pulses the PC needs, including its split low/high increment, branch page-cross fix-up and
//  2-byte vector reads.
// PARAMETERS
//  VEC_PAGE  8'hFF  high byte of the vector table address
// PORTS
//  CLK        in   1   clock; all state changes on rising edge
//  R          in   1   reset, asynchronous, active-low
//  CMD_VALID  in   1   decoder presents a command
//  CMD        in   2   0=FETCH 1=BRANCH 2=JUMP 3=VECTOR
//  CMD_READY  out  1   sequencer idle; command accepted when CMD_VALID&CMD_READY
//  LEN        in   2   FETCH: bytes to advance (0..3)
//  OFF        in   8   BRANCH: signed displacement
//  TAKEN      in   1   BRANCH: condition true
//  ADDR       in   16  JUMP: target
//  VSEL       in   2   VECTOR: 1=NMI(FA) 2=RESET(FC) 3=IRQ(FE); 0 treated as RESET
//  PC_IN      in   16  current PC value from the counter
//  CO_IN      in   1   counter carry pending (low byte wrapped, high not yet incremented)
//  DIN        in   8   bus read data, valid the cycle after VRD
//  VADDR      out  16  vector read address
//  VRD        out  1   vector read strobe
//  PC_LO, PC_HI  out 8 each  load value to counter
//  PC_CI      out  1   carry value loaded with PC_WR (always 0)
//  PC_WR      out  1   load counter
//  PC_INC     out  1   increment counter
//  PENALTY    out  1   1-cycle pulse: taken branch crossed a page
//  DONE       out  1   1-cycle pulse on final cycle of a command
// BEHAVIOUR
//  - Reset (R=0, async): state IDLE, counters/latches cleared. All outputs 0 except CMD_READY=1.
//    Reset mid-command abandons it; no further WR/INC.
//  - Effective PC: EPC = PC_IN + (CO_IN<<8). Used by BRANCH and JUMP-relative maths.
//  - States: IDLE, ADV, BR_HI, VLO, VHI, VLD. CMD_READY = (state==IDLE). Command is latched on accept.
//  - FETCH: cnt<=LEN. LEN=0: DONE on the accept cycle, no INC. Else go to ADV.
//    In ADV, PC_INC=1 every cycle. An INC with CO_IN=0 consumes one byte (cnt-1).
//    An INC with CO_IN=1 only propagates carry, so cnt is unchanged.
//    DONE is asserted with the last consuming INC, then return to IDLE.
//    CO_IN may remain 1 after DONE and is resolved by the next INC.
//  - BRANCH not taken: DONE on the accept cycle, no PC activity.
//  - BRANCH taken, accept cycle: T = EPC + sext(OFF).
//    PC_WR=1, PC_LO=T[7:0], PC_HI=EPC[15:8], PC_CI=0.
//    If T[15:8]==EPC[15:8], DONE on the same cycle.
//    Else go to BR_HI: PC_WR=1, PC_LO=T[7:0], PC_HI=T[15:8], PENALTY=1, DONE=1.
//  - JUMP: accept cycle PC_WR=1, {PC_HI,PC_LO}=ADDR, DONE=1. Single cycle.
//  - VECTOR:
//    VLO: VADDR={VEC_PAGE,base}, VRD=1.
//    VHI: latch lo<=DIN; VADDR=base+1, VRD=1.
//    VLD: PC_WR=1, PC_LO=lo, PC_HI=DIN, DONE=1.
//    Base: FA/FC/FE. Three cycles after accept.
//  - WR and INC are never asserted together. PC_WR always loads CI=0, clearing any pending carry.
//  - Address arithmetic is 16-bit modulo: FFFF+1 wraps to 0000; 0000+sext(80) gives FF80.
//  - CMD_VALID while busy is ignored. The decoder holds it until CMD_READY.
// STRUCTURE
//  - pc_seq_pkg holds CMD_* encodings, state enum, VEC_NMI/RESET/IRQ low-byte constants.
//  - One natural sub-module, pc_seq_brcalc (combinational): EPC, T, page_cross.
//  - Outputs are decoded from registered state plus latched command fields.
// TESTING
//  - FETCH LEN=3, PC=12FE, CO=0 (bench models the counter):
//    3 consuming INCs + 1 carry INC; PC=1301; DONE on the 4th INC cycle.
//  - BRANCH taken OFF=05, PC=2010: one WR to 2015, DONE same cycle, PENALTY=0.
//  - BRANCH taken OFF=F0, PC=2005:
//    WR 20F5 then WR 1FF5 next cycle, PENALTY=1 on 2nd cycle.
//  - BRANCH TAKEN=0: DONE on accept cycle, no WR/INC.
//    JUMP ADDR=C000: WR C000 with CI=0.
//  - VECTOR VSEL=2, memory FFFC=34 FFFD=12: VRD at FFFC then FFFD; WR 1234 on 3rd cycle.
//  - Reset asserted during VHI: VRD/PC_WR drop at once, CMD_READY=1, no load after release.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared encodings for the program-counter sequencer
package pc_seq_pkg;

  localparam logic [1:0] CMD_FETCH  = 2'd0;
  localparam logic [1:0] CMD_BRANCH = 2'd1;
  localparam logic [1:0] CMD_JUMP   = 2'd2;
  localparam logic [1:0] CMD_VECTOR = 2'd3;

  localparam logic [7:0] VEC_NMI   = 8'hFA;
  localparam logic [7:0] VEC_RESET = 8'hFC;
  localparam logic [7:0] VEC_IRQ   = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADV,
    ST_BR_HI,
    ST_VLO,
    ST_VHI,
    ST_VLD
  } state_e;

  // An unused selector falls back to the reset vector.
  function automatic logic [7:0] vec_base(input logic [1:0] vsel);
    case (vsel)
      2'd1:    return VEC_NMI;
      2'd3:    return VEC_IRQ;
      default: return VEC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/pc_seq_brcalc.sv
// rtl/pc_seq_brcalc.sv - branch target arithmetic on the carry-resolved PC
module pc_seq_brcalc (
  input  logic [15:0] pc_in,
  input  logic        co_in,
  input  logic [7:0]  off,
  output logic [15:0] epc,
  output logic [15:0] t,
  output logic        page_cross
);

  assign epc        = pc_in + {7'd0, co_in, 8'd0};
  assign t          = epc + {{8{off[7]}}, off};
  assign page_cross = (t[15:8] != epc[15:8]);

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - turns decoder commands into WR/INC cycles for the 16-bit program counter
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [7:0] VEC_PAGE = 8'hFF
) (
  input  logic        CLK,
  input  logic        R,
  input  logic        CMD_VALID,
  input  logic [1:0]  CMD,
  output logic        CMD_READY,
  input  logic [1:0]  LEN,
  input  logic [7:0]  OFF,
  input  logic        TAKEN,
  input  logic [15:0] ADDR,
  input  logic [1:0]  VSEL,
  input  logic [15:0] PC_IN,
  input  logic        CO_IN,
  input  logic [7:0]  DIN,
  output logic [15:0] VADDR,
  output logic        VRD,
  output logic [7:0]  PC_LO,
  output logic [7:0]  PC_HI,
  output logic        PC_CI,
  output logic        PC_WR,
  output logic        PC_INC,
  output logic        PENALTY,
  output logic        DONE
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] t_q, t_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  lo_q, lo_d;

  logic [15:0] epc;
  logic [15:0] t;
  logic        page_cross;
  logic        accept;

  pc_seq_brcalc u_brcalc (
    .pc_in      (PC_IN),
    .co_in      (CO_IN),
    .off        (OFF),
    .epc        (epc),
    .t          (t),
    .page_cross (page_cross)
  );

  // Gating with R keeps every strobe quiet while reset is held.
  assign accept = CMD_VALID && (state_q == ST_IDLE) && R;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    base_d    = base_q;
    lo_d      = lo_q;
    CMD_READY = (state_q == ST_IDLE);
    VADDR     = 16'h0000;
    VRD       = 1'b0;
    PC_LO     = 8'h00;
    PC_HI     = 8'h00;
    PC_CI     = 1'b0;
    PC_WR     = 1'b0;
    PC_INC    = 1'b0;
    PENALTY   = 1'b0;
    DONE      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (CMD)
            CMD_FETCH: begin
              cnt_d = LEN;
              if (LEN == 2'd0) DONE = 1'b1;
              else             state_d = ST_ADV;
            end
            CMD_BRANCH: begin
              if (!TAKEN) begin
                DONE = 1'b1;
              end else begin
                PC_WR = 1'b1;
                PC_LO = t[7:0];
                PC_HI = epc[15:8];
                t_d   = t;
                if (page_cross) state_d = ST_BR_HI;
                else            DONE    = 1'b1;
              end
            end
            CMD_JUMP: begin
              PC_WR = 1'b1;
              PC_LO = ADDR[7:0];
              PC_HI = ADDR[15:8];
              DONE  = 1'b1;
            end
            default: begin
              base_d  = vec_base(VSEL);
              state_d = ST_VLO;
            end
          endcase
        end
      end
      ST_ADV: begin
        PC_INC = 1'b1;
        // A carry-propagating increment does not advance past a byte.
        if (!CO_IN) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            DONE    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_BR_HI: begin
        PC_WR   = 1'b1;
        PC_LO   = t_q[7:0];
        PC_HI   = t_q[15:8];
        PENALTY = 1'b1;
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_VLO: begin
        VADDR   = {VEC_PAGE, base_q};
        VRD     = 1'b1;
        state_d = ST_VHI;
      end
      ST_VHI: begin
        lo_d    = DIN;
        VADDR   = {VEC_PAGE, base_q} + 16'd1;
        VRD     = 1'b1;
        state_d = ST_VLD;
      end
      ST_VLD: begin
        PC_WR   = 1'b1;
        PC_LO   = lo_q;
        PC_HI   = DIN;
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      t_q     <= 16'h0000;
      base_q  <= 8'h00;
      lo_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      base_q  <= base_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - scoreboard bench for pc_seq with a counter and vector-memory model
module tb_pc_seq;
  import pc_seq_pkg::*;

  logic        CLK = 1'b0;
  logic        R = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic [1:0]  CMD = 2'd0;
  logic [1:0]  LEN = 2'd0;
  logic [7:0]  OFF = 8'h00;
  logic        TAKEN = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic [1:0]  VSEL = 2'd0;
  logic [15:0] PC_IN;
  logic        CO_IN;
  logic [7:0]  DIN = 8'h00;
  logic        CMD_READY, VRD, PC_CI, PC_WR, PC_INC, PENALTY, DONE;
  logic [15:0] VADDR;
  logic [7:0]  PC_LO, PC_HI;

  typedef struct packed {
    logic        wr;
    logic        inc;
    logic        vrd;
    logic        done;
    logic        pen;
    logic        ci;
    logic [15:0] vaddr;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } ev_t;

  typedef struct {
    string name;
    ev_t   ev;
  } sb_t;

  sb_t  exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  logic [15:0] pc_m = 16'h0000;
  logic        co_m = 1'b0;
  logic [15:0] pre_pc = 16'h0000;
  logic        pre_co = 1'b0;
  logic        pre_en = 1'b0;

  always #5 CLK = ~CLK;

  pc_seq #(.VEC_PAGE(8'hFF)) dut (
    .CLK(CLK), .R(R), .CMD_VALID(CMD_VALID), .CMD(CMD), .CMD_READY(CMD_READY),
    .LEN(LEN), .OFF(OFF), .TAKEN(TAKEN), .ADDR(ADDR), .VSEL(VSEL),
    .PC_IN(PC_IN), .CO_IN(CO_IN), .DIN(DIN), .VADDR(VADDR), .VRD(VRD),
    .PC_LO(PC_LO), .PC_HI(PC_HI), .PC_CI(PC_CI), .PC_WR(PC_WR),
    .PC_INC(PC_INC), .PENALTY(PENALTY), .DONE(DONE)
  );

  assign PC_IN = pc_m;
  assign CO_IN = co_m;

  // Split-increment program counter: low byte wraps into a pending carry.
  always @(posedge CLK) begin
    if (pre_en) begin
      pc_m <= pre_pc;
      co_m <= pre_co;
    end else if (PC_WR) begin
      pc_m <= {PC_HI, PC_LO};
      co_m <= PC_CI;
    end else if (PC_INC) begin
      if (co_m) begin
        pc_m[15:8] <= pc_m[15:8] + 8'd1;
        co_m       <= 1'b0;
      end else begin
        {co_m, pc_m[7:0]} <= {1'b0, pc_m[7:0]} + 9'd1;
      end
    end
  end

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h78;
      16'hFFFB: return 8'h56;
      16'hFFFC: return 8'h34;
      16'hFFFD: return 8'h12;
      16'hFFFE: return 8'hCD;
      16'hFFFF: return 8'hAB;
      default:  return 8'h00;
    endcase
  endfunction

  always @(posedge CLK) DIN <= VRD ? mem_rd(VADDR) : 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic ev_t mk(input logic wr, input logic inc, input logic vrd,
                             input logic done, input logic pen, input logic [15:0] vaddr,
                             input logic [7:0] lo, input logic [7:0] hi);
    ev_t e;
    e = '{wr: wr, inc: inc, vrd: vrd, done: done, pen: pen, ci: 1'b0,
          vaddr: vaddr, lo: lo, hi: hi};
    return e;
  endfunction

  task automatic push(input string name, input ev_t e);
    sb_t s;
    s.name = name;
    s.ev   = e;
    exp_q.push_back(s);
  endtask

  // Monitor: every cycle with any strobe active must match the next expected event.
  always @(negedge CLK) begin
    ev_t act;
    sb_t s;
    act = '{wr: PC_WR, inc: PC_INC, vrd: VRD, done: DONE, pen: PENALTY, ci: PC_CI,
            vaddr: VADDR, lo: PC_LO, hi: PC_HI};
    if (PC_WR || PC_INC || VRD || DONE || PENALTY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(act), 64'd0);
      end else begin
        s = exp_q.pop_front();
        chk(s.name, 64'(act), 64'(s.ev));
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      if (CMD_READY) break;
      @(posedge CLK); #1;
    end
    chk("cmd_ready", 64'(CMD_READY), 64'd1);
  endtask

  task automatic set_pc(input logic [15:0] p, input logic c);
    @(posedge CLK); #1;
    pre_pc = p; pre_co = c; pre_en = 1'b1;
    @(posedge CLK); #1;
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c, input logic [1:0] len, input logic [7:0] off,
                       input logic taken, input logic [15:0] addr, input logic [1:0] vsel);
    wait_ready();
    CMD = c; LEN = len; OFF = off; TAKEN = taken; ADDR = addr; VSEL = vsel;
    CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    wait_ready();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge CLK);
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_ready", 64'(CMD_READY), 64'd1);
    chk("reset_strobes", 64'({PC_WR, PC_INC, VRD, DONE, PENALTY, PC_CI}), 64'd0);
    chk("reset_buses", 64'({VADDR, PC_LO, PC_HI}), 64'd0);
    @(posedge CLK); #1;
    R = 1'b1;

    set_pc(16'h12FE, 1'b0);
    push("fetch3_inc1", mk(0, 1, 0, 0, 0, 16'h0, 8'h00, 8'h00));
    push("fetch3_inc2", mk(0, 1, 0, 0, 0, 16'h0, 8'h00, 8'h00));
    push("fetch3_carry", mk(0, 1, 0, 0, 0, 16'h0, 8'h00, 8'h00));
    push("fetch3_done", mk(0, 1, 0, 1, 0, 16'h0, 8'h00, 8'h00));
    issue(CMD_FETCH, 2'd3, 8'h00, 1'b0, 16'h0000, 2'd0);
    drain();
    chk("fetch3_pc", 64'({co_m, pc_m}), 64'h1301);

    push("fetch0_done", mk(0, 0, 0, 1, 0, 16'h0, 8'h00, 8'h00));
    issue(CMD_FETCH, 2'd0, 8'h00, 1'b0, 16'h0000, 2'd0);

    set_pc(16'h2010, 1'b0);
    push("br_same_page", mk(1, 0, 0, 1, 0, 16'h0, 8'h15, 8'h20));
    issue(CMD_BRANCH, 2'd0, 8'h05, 1'b1, 16'h0000, 2'd0);
    chk("br_same_pc", 64'(pc_m), 64'h2015);

    set_pc(16'h2005, 1'b0);
    push("br_cross_lo", mk(1, 0, 0, 0, 0, 16'h0, 8'hF5, 8'h20));
    push("br_cross_hi", mk(1, 0, 0, 1, 1, 16'h0, 8'hF5, 8'h1F));
    issue(CMD_BRANCH, 2'd0, 8'hF0, 1'b1, 16'h0000, 2'd0);
    chk("br_cross_pc", 64'(pc_m), 64'h1FF5);

    set_pc(16'h2000, 1'b1);
    push("br_carry_epc", mk(1, 0, 0, 1, 0, 16'h0, 8'h10, 8'h21));
    issue(CMD_BRANCH, 2'd0, 8'h10, 1'b1, 16'h0000, 2'd0);
    chk("br_carry_cleared", 64'({co_m, pc_m}), 64'h2110);

    set_pc(16'h0000, 1'b0);
    push("br_wrap_lo", mk(1, 0, 0, 0, 0, 16'h0, 8'h80, 8'h00));
    push("br_wrap_hi", mk(1, 0, 0, 1, 1, 16'h0, 8'h80, 8'hFF));
    issue(CMD_BRANCH, 2'd0, 8'h80, 1'b1, 16'h0000, 2'd0);
    chk("br_wrap_pc", 64'(pc_m), 64'hFF80);

    push("br_not_taken", mk(0, 0, 0, 1, 0, 16'h0, 8'h00, 8'h00));
    issue(CMD_BRANCH, 2'd0, 8'h40, 1'b0, 16'h0000, 2'd0);
    chk("br_not_taken_pc", 64'(pc_m), 64'hFF80);

    push("jump", mk(1, 0, 0, 1, 0, 16'h0, 8'h00, 8'hC0));
    issue(CMD_JUMP, 2'd0, 8'h00, 1'b0, 16'hC000, 2'd0);

    push("vec_reset_lo", mk(0, 0, 1, 0, 0, 16'hFFFC, 8'h00, 8'h00));
    push("vec_reset_hi", mk(0, 0, 1, 0, 0, 16'hFFFD, 8'h00, 8'h00));
    push("vec_reset_ld", mk(1, 0, 0, 1, 0, 16'h0, 8'h34, 8'h12));
    issue(CMD_VECTOR, 2'd0, 8'h00, 1'b0, 16'h0000, 2'd2);
    chk("vec_reset_pc", 64'(pc_m), 64'h1234);

    push("vec_irq_lo", mk(0, 0, 1, 0, 0, 16'hFFFE, 8'h00, 8'h00));
    push("vec_irq_hi", mk(0, 0, 1, 0, 0, 16'hFFFF, 8'h00, 8'h00));
    push("vec_irq_ld", mk(1, 0, 0, 1, 0, 16'h0, 8'hCD, 8'hAB));
    issue(CMD_VECTOR, 2'd0, 8'h00, 1'b0, 16'h0000, 2'd3);
    chk("vec_irq_pc", 64'(pc_m), 64'hABCD);

    set_pc(16'h4444, 1'b0);
    push("vec_nmi_lo", mk(0, 0, 1, 0, 0, 16'hFFFA, 8'h00, 8'h00));
    wait_ready();
    CMD = CMD_VECTOR; VSEL = 2'd1; CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    @(posedge CLK); #1;
    R = 1'b0;
    #1;
    chk("rst_mid_strobes", 64'({VRD, PC_WR, DONE}), 64'd0);
    chk("rst_mid_ready", 64'(CMD_READY), 64'd1);
    repeat (2) @(posedge CLK);
    #1;
    R = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    chk("rst_mid_no_load", 64'(pc_m), 64'h4444);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
